// File: rtl/poly1305_serial_verifier.sv
// Poly1305 receive-side tag verifier.
// Absorbs one 16-byte message block per cycle over a valid/ready handshake.
// The finished tag is compared with the expected tag using a full-width
// XOR/OR reduction, so the result timing never depends on the data.
module poly1305_serial_verifier (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [127:0] expected_tag,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic [127:0] round_input,
    input  logic [3:0]   number_of_input_bytes_minus_one,
    input  logic         last,
    output logic         busy,
    output logic         done,
    output logic         tag_ok,
    output logic [127:0] tag
);

    // Prime 2^130 - 5
    localparam logic [129:0] P1305      = {2'b11, {31{4'hf}}, 4'hb};
    localparam logic [127:0] CLAMP_MASK = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ABSORB  = 2'd1,
        ST_FINAL   = 2'd2,
        ST_COMPARE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [129:0]  r_acc;
    logic [127:0]  r_r;
    logic [127:0]  r_s;
    logic [127:0]  r_exp;
    logic [127:0]  r_tag;
    logic          r_tag_ok;
    logic          r_done;
    logic          w_xfer;

    // Clear the bits of r that Poly1305 requires to be zero.
    function automatic logic [127:0] poly1305_clamp(input logic [127:0] r_raw);
        return r_raw & CLAMP_MASK;
    endfunction

    // One Poly1305 block step: acc = ((acc + padded_block) * r) mod (2^130 - 5),
    // returning a fully reduced accumulator.
    function automatic logic [129:0] poly1305_block(
        input logic [129:0] acc,
        input logic [127:0] r,
        input logic [127:0] m,
        input logic [3:0]   len_m1
    );
        logic [127:0] mask;
        logic [7:0]   pad_pos;
        logic [128:0] n;
        logic [130:0] sum;
        logic [258:0] prod;
        logic [128:0] hi;
        logic [132:0] fold1;
        logic [130:0] fold2;
        logic [129:0] res;
        // keep only the valid low bytes, then append the 0x01 pad byte above them
        mask    = {128{1'b1}} >> {(4'd15 - len_m1), 3'b000};
        pad_pos = {1'b0, len_m1, 3'b000} + 8'd8;
        n       = {1'b0, m & mask} | (129'd1 << pad_pos);
        sum     = {1'b0, acc} + {2'b00, n};
        prod    = {128'd0, sum} * {131'd0, r};
        // 2^130 == 5 (mod p): fold the high part down twice
        hi      = prod[258:130];
        fold1   = {3'b000, prod[129:0]} + {2'b00, hi, 2'b00} + {4'b0000, hi};
        fold2   = {1'b0, fold1[129:0]}
                + {126'd0, fold1[132:130], 2'b00}
                + {128'd0, fold1[132:130]};
        // fold2 < 2p here, so one conditional subtraction finishes the reduction
        if (fold2 >= {1'b0, P1305}) begin
            res = fold2[129:0] - P1305;
        end else begin
            res = fold2[129:0];
        end
        return res;
    endfunction

    assign w_xfer = block_valid & block_ready;
    assign done   = r_done;
    assign tag_ok = r_tag_ok;
    assign tag    = r_tag;

    // State register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; start overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        block_ready = 1'b0;
        busy        = (r_state != ST_IDLE);
        if (start) begin
            w_state_nxt = ST_ABSORB;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_ABSORB: begin
                    block_ready = 1'b1;
                    if (block_valid && last) begin
                        w_state_nxt = ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    w_state_nxt = ST_COMPARE;
                end
                ST_COMPARE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Key/tag latching, accumulation, finalisation and constant-time compare.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_acc    <= '0;
            r_r      <= '0;
            r_s      <= '0;
            r_exp    <= '0;
            r_tag    <= '0;
            r_tag_ok <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_r      <= poly1305_clamp(key[127:0]);
                r_s      <= key[255:128];
                r_exp    <= expected_tag;
                r_acc    <= '0;
                r_tag    <= '0;
                r_tag_ok <= 1'b0;
            end else begin
                case (r_state)
                    ST_ABSORB: begin
                        if (w_xfer) begin
                            r_acc <= poly1305_block(r_acc, r_r, round_input,
                                                    number_of_input_bytes_minus_one);
                        end
                    end
                    ST_FINAL: begin
                        // carry out of bit 127 is discarded
                        r_tag <= r_acc[127:0] + r_s;
                    end
                    ST_COMPARE: begin
                        r_tag_ok <= ~|(r_tag ^ r_exp);
                        r_done   <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_poly1305_serial_verifier.sv
// Self-checking bench for poly1305_serial_verifier: RFC 8439 vectors, corner
// sequences (backpressure, abort, reset, restart on done) and random messages
// against an arithmetic reference model.
module tb_poly1305_serial_verifier;

    localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

    logic         clock = 1'b0;
    logic         clear_n;
    logic         start;
    logic [255:0] key;
    logic [127:0] expected_tag;
    logic         block_valid;
    logic         block_ready;
    logic [127:0] round_input;
    logic [3:0]   number_of_input_bytes_minus_one;
    logic         last;
    logic         busy;
    logic         done;
    logic         tag_ok;
    logic [127:0] tag;

    int n_err    = 0;
    int n_checks = 0;
    int done_cnt = 0;

    logic [7:0] g_msg[$];
    int         g_gaps[$];

    logic [255:0] rfc_key;
    logic [127:0] rfc_tag;

    typedef struct {
        logic [255:0] k;
        logic [127:0] et;
        int           nbytes;
        logic [127:0] tag;
        logic         ok;
    } vec_t;
    vec_t vecs[5];

    poly1305_serial_verifier dut (
        .clock                          (clock),
        .clear_n                        (clear_n),
        .start                          (start),
        .key                            (key),
        .expected_tag                   (expected_tag),
        .block_valid                    (block_valid),
        .block_ready                    (block_ready),
        .round_input                    (round_input),
        .number_of_input_bytes_minus_one(number_of_input_bytes_minus_one),
        .last                           (last),
        .busy                           (busy),
        .done                           (done),
        .tag_ok                         (tag_ok),
        .tag                            (tag)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] bswap256(input logic [255:0] x);
        logic [255:0] y;
        for (int i = 0; i < 32; i++) y[8*i +: 8] = x[8*(31-i) +: 8];
        return y;
    endfunction

    function automatic logic [127:0] bswap128(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
        return y;
    endfunction

    // Reference: Poly1305 over g_msg with plain wide arithmetic and modulo.
    function automatic logic [127:0] model_tag(input logic [255:0] k);
        logic [263:0] acc;
        logic [263:0] n;
        logic [263:0] r;
        logic [263:0] p;
        logic [263:0] t;
        int           nbytes;
        int           cnt;
        nbytes = g_msg.size();
        p   = (264'd1 << 130) - 264'd5;
        r   = {136'd0, k[127:0] & CLAMP};
        acc = '0;
        for (int b = 0; b * 16 < nbytes; b++) begin
            n   = '0;
            cnt = 0;
            for (int i = 0; i < 16 && b * 16 + i < nbytes; i++) begin
                n[8*i +: 8] = g_msg[b*16+i];
                cnt = i + 1;
            end
            n   = n + (264'd1 << (8 * cnt));
            acc = ((acc + n) * r) % p;
        end
        t = acc + {136'd0, k[255:128]};
        return t[127:0];
    endfunction

    task automatic load_rfc_msg(input int nbytes);
        string s;
        s = "Cryptographic Forum Research Group";
        g_msg.delete();
        for (int i = 0; i < nbytes; i++) g_msg.push_back(s[i]);
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    function automatic logic [127:0] rand128();
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Runs one message from g_msg with idle gaps from g_gaps, checks latency,
    // tag, tag_ok and that exactly one done pulse occurs.
    task automatic run_msg(input logic [255:0] k, input logic [127:0] et,
                           input logic [127:0] exp_tag, input logic exp_ok,
                           input logic junk, input logic restart, input string name);
        int           nbytes;
        int           nblk;
        int           base_done;
        int           lat;
        int           gap;
        int           nb;
        logic         seen;
        logic [127:0] d;
        nbytes = g_msg.size();
        nblk   = (nbytes + 15) / 16;
        start = 1'b1; key = k; expected_tag = et;
        block_valid = junk; round_input = rand128();
        number_of_input_bytes_minus_one = 4'd15; last = junk;
        @(posedge clock); #1;
        start = 1'b0; block_valid = 1'b0; last = 1'b0;
        key = rand_key(); expected_tag = rand128();
        base_done = done_cnt;
        for (int b = 0; b < nblk; b++) begin
            gap = (b < g_gaps.size()) ? g_gaps[b] : 0;
            nb  = nbytes - 16 * b;
            if (nb > 16) nb = 16;
            d = rand128();
            for (int i = 0; i < nb; i++) d[8*i +: 8] = g_msg[16*b+i];
            repeat (gap) begin
                @(posedge clock); #1;
            end
            block_valid = 1'b1; round_input = d;
            number_of_input_bytes_minus_one = 4'(nb - 1);
            last = (b == nblk - 1);
            @(negedge clock);
            check({name, "_ready"}, 128'(block_ready), 128'd1);
            @(posedge clock); #1;
            block_valid = 1'b0; last = 1'b0; round_input = rand128();
        end
        seen = 1'b0; lat = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1; lat = c;
            end
        end
        check({name, "_done_latency"}, 128'(lat), 128'd3);
        if (seen) begin
            check({name, "_tag"}, tag, exp_tag);
            check({name, "_tag_ok"}, 128'(tag_ok), 128'(exp_ok));
            check({name, "_busy_at_done"}, 128'(busy), 128'd0);
            if (restart) begin
                start = 1'b1; key = k; expected_tag = et;
                @(posedge clock); #1;
                start = 1'b0;
                @(negedge clock);
                check({name, "_restart_tag"}, tag, 128'd0);
                check({name, "_restart_ok"}, 128'(tag_ok), 128'd0);
                check({name, "_restart_done"}, 128'(done), 128'd0);
                check({name, "_restart_busy"}, 128'(busy), 128'd1);
            end else begin
                @(negedge clock);
                check({name, "_done_pulse"}, 128'(done), 128'd0);
            end
        end
        check({name, "_done_count"}, 128'(done_cnt - base_done), 128'd1);
    endtask

    initial begin
        logic [255:0] k;
        logic [127:0] mt;
        logic [127:0] et;
        logic         flip;
        int           base;
        int           len;

        rfc_key = bswap256(256'h85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b);
        rfc_tag = bswap128(128'ha8061dc1305136c6c22b8baf0c0127a9);

        vecs[0] = '{rfc_key, rfc_tag,                  34, rfc_tag, 1'b1};
        vecs[1] = '{rfc_key, rfc_tag ^ (128'd1 << 127), 34, rfc_tag, 1'b0};
        vecs[2] = '{rfc_key, rfc_tag ^ 128'd1,          34, rfc_tag, 1'b0};
        vecs[3] = '{256'd0,  128'd0,                    16, 128'd0,  1'b1};
        vecs[4] = '{256'd0,  128'd1,                    16, 128'd0,  1'b0};

        clear_n = 1'b0; start = 1'b0; key = '0; expected_tag = '0;
        block_valid = 1'b0; round_input = '0;
        number_of_input_bytes_minus_one = 4'd0; last = 1'b0;

        // reset state
        @(negedge clock);
        check("rst_busy",  128'(busy), 128'd0);
        check("rst_ready", 128'(block_ready), 128'd0);
        check("rst_done",  128'(done), 128'd0);
        check("rst_ok",    128'(tag_ok), 128'd0);
        check("rst_tag",   tag, 128'd0);
        @(posedge clock); #1;
        clear_n = 1'b1;
        @(posedge clock); #1;

        // table-driven vectors
        for (int v = 0; v < 5; v++) begin
            load_rfc_msg(vecs[v].nbytes);
            g_gaps.delete();
            run_msg(vecs[v].k, vecs[v].et, vecs[v].tag, vecs[v].ok, 1'b0, 1'b0,
                    $sformatf("vec%0d", v));
        end

        // backpressure: valid pattern 1,0,0,1,0,1 plus a junk block during start
        load_rfc_msg(34);
        g_gaps.delete();
        g_gaps.push_back(0); g_gaps.push_back(2); g_gaps.push_back(1);
        run_msg(rfc_key, rfc_tag, rfc_tag, 1'b1, 1'b1, 1'b0, "backpressure");
        g_gaps.delete();

        // abort in ABSORB, FINAL and COMPARE, then a full RFC run
        for (int ab = 0; ab < 3; ab++) begin
            start = 1'b1; key = rand_key(); expected_tag = rand128();
            @(posedge clock); #1;
            start = 1'b0;
            block_valid = 1'b1; round_input = rand128();
            number_of_input_bytes_minus_one = 4'd15; last = (ab != 0);
            @(posedge clock); #1;
            block_valid = 1'b0; last = 1'b0;
            if (ab == 2) begin
                @(posedge clock); #1;
            end
            load_rfc_msg(34);
            run_msg(rfc_key, rfc_tag, rfc_tag, 1'b1, 1'b0, 1'b0, $sformatf("abort%0d", ab));
        end

        // reset mid-message
        base = done_cnt;
        load_rfc_msg(34);
        start = 1'b1; key = rfc_key; expected_tag = rfc_tag;
        @(posedge clock); #1;
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            block_valid = 1'b1; round_input = rand128();
            number_of_input_bytes_minus_one = 4'd15; last = 1'b0;
            @(posedge clock); #1;
        end
        block_valid = 1'b0;
        clear_n = 1'b0;
        #2;
        check("midrst_busy",  128'(busy), 128'd0);
        check("midrst_ready", 128'(block_ready), 128'd0);
        check("midrst_tag",   tag, 128'd0);
        check("midrst_ok",    128'(tag_ok), 128'd0);
        @(posedge clock); #1;
        clear_n = 1'b1;
        repeat (6) begin
            @(posedge clock); #1;
        end
        check("midrst_no_done", 128'(done_cnt - base), 128'd0);
        check("midrst_idle",    128'(busy), 128'd0);
        run_msg(rfc_key, rfc_tag, rfc_tag, 1'b1, 1'b0, 1'b0, "after_reset");

        // start in the same cycle as done
        run_msg(rfc_key, rfc_tag, rfc_tag, 1'b1, 1'b0, 1'b1, "restart_on_done");

        // randomized messages against the reference model
        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(1, 64);
            g_msg.delete();
            for (int i = 0; i < len; i++) g_msg.push_back(8'($urandom));
            g_gaps.delete();
            for (int b = 0; b < (len + 15) / 16; b++) g_gaps.push_back($urandom_range(0, 2));
            k    = rand_key();
            mt   = model_tag(k);
            flip = $urandom_range(0, 1);
            et   = flip ? (mt ^ (128'd1 << $urandom_range(0, 127))) : mt;
            run_msg(k, et, mt, !flip, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/poly1305_serial_verifier.md
Name: poly1305_serial_verifier

Overview:
Receive-side counterpart of the Poly1305 serial tag encoder. Accepts a one-time key and an expected tag, then absorbs message blocks over a valid/ready handshake. It computes the Poly1305 tag and compares it against the expected tag in constant time, and reports a single authenticated / not-authenticated result. Sits in the AEAD decrypt path, in front of plaintext release.

Parameters:
None. Widths are fixed by Poly1305: key 256, block 128, accumulator 130, tag 128.

Ports:
clock  input  1  rising-edge clock
clear_n  input  1  asynchronous, active-low reset
start  input  1  begin a new message; latches key and expected_tag
key  input  256  one-time key; r = key[127:0] (clamped internally via poly1305_clamp), s = key[255:128]
expected_tag  input  128  received tag, little-endian (byte 0 in [7:0])
block_valid  input  1  round_input / length / last are valid
block_ready  output  1  verifier can accept a block this cycle
round_input  input  128  message block, little-endian, unused high bytes don't-care
number_of_input_bytes_minus_one  input  4  valid bytes in block minus one (15 = full block)
last  input  1  qualifies the final block of the message
busy  output  1  message in progress (any state except IDLE)
done  output  1  one-cycle pulse: result valid
tag_ok  output  1  1 = computed tag equals expected_tag; held until next start
tag  output  128  computed tag (debug/visibility), held until next start

Behaviour:
- Reset (clear_n low, asynchronous): state IDLE, acc=0, r/s/expected regs=0, block_ready=0, busy=0, done=0, tag_ok=0, tag=0.
- States: IDLE, ABSORB, FINAL, COMPARE.
- IDLE: block_ready=0. On start=1: latch clamped r, s and expected_tag; acc<=0; tag_ok<=0; tag<=0; go to ABSORB.
- ABSORB: block_ready=1. Transfer = block_valid & block_ready.
  - On transfer: acc <= poly1305_block(acc, r, round_input, number_of_input_bytes_minus_one), so one block per cycle.
  - Transfer with last=1: go to FINAL. No transfer: hold acc.
- FINAL: block_ready=0. tag <= (acc[127:0] + s) mod 2^128. Go to COMPARE.
- COMPARE: tag_ok <= ~|(tag ^ expected_reg), computed as a full 128-bit XOR/OR reduction with no early exit. done=1 for the cycle after this edge. Go to IDLE.
- Latency: if the last-block transfer occurs in cycle N, done is high in cycle N+3 only. Latency is independent of data and of the comparison outcome.
- start has priority in every state. In ABSORB, FINAL or COMPARE it aborts the current message, relatches key and expected_tag, clears acc, and re-enters ABSORB. The aborted message produces no done pulse. A block presented in the same cycle as start is not consumed.
- start in the same cycle that done is high: accepted normally, and tag_ok/tag clear at that edge.
- Partial blocks (number_of_input_bytes_minus_one < 15) are legal only with last=1. Otherwise the result is defined solely by poly1305_block, and the verifier does not flag it.
- Zero-block messages are not supported; a message has at least one block.
- Inputs key and expected_tag may change after the start cycle without effect.
- clear_n asserted mid-message: all state returns to reset values immediately, no done pulse. Operation resumes only on a fresh start after deassertion.
- Arithmetic: acc is 130 bits, reduced mod 2^130-5 inside poly1305_block. The final add truncates to 128 bits (carry discarded).

Test Plan:
- RFC 8439 §2.5.2 key 85d6be78...f5 1b. Stimulus: "Cryptographic Forum Research Group" as 3 blocks with lengths-1 = 15, 15, 1 and last on the third, expected_tag = RFC tag. Required: done exactly 3 cycles after the third transfer, tag = RFC tag, tag_ok=1.
- Same as above with expected_tag bit 127 flipped -> done at the identical cycle, tag unchanged, tag_ok=0. Repeat with bit 0 flipped -> same.
- Backpressure: block_valid toggled 1,0,0,1,0,1 across the same 3 blocks -> identical tag and tag_ok=1. acc is unchanged during idle cycles.
- Abort: start, 1 block, then start with a new key, then the full RFC message -> exactly one done pulse, tag_ok=1.
- Reset: clear_n low for 1 cycle after 2 blocks -> busy=0, block_ready=0, done never pulses. A subsequent full run passes.
- Single 16-byte block, key = all zero, expected_tag = 0 -> tag=0, tag_ok=1, done 3 cycles after the transfer.
